spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, TX and RX FIFO depth in bytes (power of 2, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, maximum clk cycles to wait for eng_BF per byte.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable, input, 1 bit: transfer enable.
REQ-006 The block SHALL have port wr_en, input, 1 bit, and port wr_data, input, 8 bits: processor push into the TX FIFO.
REQ-007 The block SHALL have port rd_en, input, 1 bit, and port rd_data, output, 8 bits: processor pop from the RX FIFO.
REQ-008 The block SHALL have ports tx_full, tx_empty, rx_full, rx_empty, busy, output, 1 bit each: status.
REQ-009 The block SHALL have ports ovf and tmo, output, 1 bit each, plus err_clr, input, 1 bit: sticky error flags and their clear.
REQ-010 The block SHALL have ports eng_in8 (output, 8 bits), eng_bufMe, eng_EN and eng_Sh (output, 1 bit each): controls to the SPI shift engine.
REQ-011 The block SHALL have ports eng_BF (input, 1 bit) and eng_out8 (input, 8 bits): status and data from the SPI shift engine.

Function
REQ-012 The TX and RX FIFOs SHALL be circular, FIFO_DEPTH entries each, with log2(FIFO_DEPTH)+1-bit pointers; full = MSBs differ and lower bits equal; empty = pointers equal.
REQ-013 A wr_en while TX is full SHALL drop the data and set ovf; a wr_en while TX is not full SHALL store wr_data in the same cycle.
REQ-014 rd_data SHALL be show-ahead (the RX head, combinational); rd_en while RX is empty SHALL be ignored with no pointer change.
REQ-015 A simultaneous push and pop on the same FIFO SHALL both take effect, leaving the count unchanged, including when the FIFO is full or empty.
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT, CAPTURE and RELEASE, described in REQ-017 to REQ-021.
REQ-017 IDLE: if enable, TX not empty and RX not full, the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 LOAD (1 cycle): eng_in8 = TX head, eng_bufMe = 1, TX pop; the FSM SHALL then go to SHIFT and clear the timeout counter.
REQ-019 SHIFT: eng_EN = eng_Sh = 1 and the counter increments each cycle; on eng_BF = 1 the FSM SHALL go to CAPTURE; when the counter reaches TIMEOUT-1 without eng_BF it SHALL set tmo and go to RELEASE.
REQ-020 CAPTURE (1 cycle): the block SHALL push eng_out8 into RX, then go to RELEASE.
REQ-021 RELEASE (1 cycle): eng_Sh = 0 and eng_EN = 0, returning the engine to its ready state; the FSM SHALL then go to IDLE.
REQ-022 If enable falls in LOAD or SHIFT, the FSM SHALL go to RELEASE on the next edge; the popped byte is discarded and not re-queued.
REQ-023 eng_bufMe SHALL be high only in LOAD; eng_EN and eng_Sh SHALL be high only in SHIFT; all engine outputs SHALL come from registers or the state decode, glitch-free.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Minimum throughput SHALL be 1 byte per (engine shift cycles + 4) clk cycles; back-to-back bytes SHALL re-enter LOAD directly from IDLE with no idle gap.
REQ-026 err_clr SHALL clear ovf and tmo; if err_clr and a new error event occur in the same cycle, the flag SHALL remain set.

Reset
REQ-027 While rst_n = 0: FSM = IDLE, all pointers = 0, counter = 0, ovf = tmo = 0, eng_bufMe = eng_EN = eng_Sh = 0, eng_in8 = 0x00.
REQ-028 While rst_n = 0: tx_empty = rx_empty = 1, tx_full = rx_full = 0, busy = 0.
REQ-029 Assertion of rst_n mid-transfer SHALL abort immediately without pushing to RX; FIFO contents are lost.

Verification
REQ-030 Write 0xA5 with enable = 1 and an engine model returning 0x3C -> one eng_bufMe pulse with eng_in8 = 0xA5; after eng_BF, rd_data = 0x3C, rx_empty = 0, tx_empty = 1.
REQ-031 Write 5 bytes with enable = 0 and FIFO_DEPTH = 4 -> tx_full = 1 and ovf = 1; the 5th byte is dropped and the first 4 are transferred in order once enable = 1.
REQ-032 Engine model never asserts eng_BF -> tmo = 1 after 64 SHIFT cycles, FSM passes through RELEASE to IDLE, RX unchanged; err_clr clears tmo.
REQ-033 Fill RX (4 transfers without rd_en) with TX still holding data -> FSM stays in IDLE; one rd_en -> the next transfer starts.
REQ-034 Drop enable in SHIFT, or pull rst_n low in SHIFT -> eng_Sh = 0 within 1 cycle, no RX push, busy = 0 within 2 cycles.
REQ-035 Simultaneous wr_en and internal pop, and simultaneous CAPTURE push and rd_en, with each FIFO full -> counts unchanged and data order preserved.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: buffers processor bytes in a TX FIFO, hands them
// one at a time to an external SPI shift engine, and collects the engine's
// received bytes in an RX FIFO. Tracks FIFO overflow and engine timeouts as
// sticky error flags.
module spi_xfer_ctrl #(
  parameter int FIFO_DEPTH = 4,  // bytes per FIFO, power of 2, >= 2
  parameter int TIMEOUT    = 64  // max SHIFT cycles to wait for eng_BF, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  // processor side
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  // status
  output logic       tx_full,
  output logic       tx_empty,
  output logic       rx_full,
  output logic       rx_empty,
  output logic       busy,
  // sticky errors
  output logic       ovf,
  output logic       tmo,
  input  logic       err_clr,
  // shift engine
  output logic [7:0] eng_in8,
  output logic       eng_bufMe,
  output logic       eng_EN,
  output logic       eng_Sh,
  input  logic       eng_BF,
  input  logic [7:0] eng_out8
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW:0]   r_tx_wr;
  logic [AW:0]   r_tx_rd;
  logic [AW:0]   r_rx_wr;
  logic [AW:0]   r_rx_rd;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_bufme;
  logic          r_eng_en;
  logic          r_eng_sh;
  logic [7:0]    r_in8;
  logic          r_ovf;
  logic          r_tmo;

  // ---------------------------------------------------------------------
  // FIFO status and handshakes
  // ---------------------------------------------------------------------
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_tx_pop;
  logic       w_tx_push;
  logic       w_rx_pop;
  logic       w_rx_push;
  logic       w_ovf_evt;
  logic       w_tmo_evt;
  logic [7:0] w_tx_head;

  // Extra pointer MSB distinguishes "wrapped once" (full) from "equal" (empty).
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) &&
                      (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) &&
                      (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);

  assign w_tx_head  = r_tx_mem[r_tx_rd[AW-1:0]];

  // LOAD always consumes the TX head, even if the transfer is then aborted.
  assign w_tx_pop   = (r_state == S_LOAD);
  // A full FIFO still accepts a push when an entry leaves in the same cycle:
  // the write lands in the slot being vacated, so the count stays put.
  assign w_tx_push  = wr_en && (!w_tx_full || w_tx_pop);
  assign w_ovf_evt  = wr_en && w_tx_full && !w_tx_pop;

  // Reading an empty RX FIFO is a no-op.
  assign w_rx_pop   = rd_en && !w_rx_empty;
  assign w_rx_push  = (r_state == S_CAPTURE) && (!w_rx_full || w_rx_pop);

  // Engine took too long: last allowed SHIFT cycle with no eng_BF.
  assign w_tmo_evt  = (r_state == S_SHIFT) && enable && !eng_BF &&
                      (r_cnt == CNT_MAX);

  // ---------------------------------------------------------------------
  // FIFO data arrays
  // ---------------------------------------------------------------------
  // Write the FIFO payload RAMs.
  // NOTE: data arrays carry no reset -- validity lives in the pointers, and
  // leaving the RAM out of the reset net lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= wr_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= eng_out8;
  end

  // Advance FIFO read/write pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
      if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------
  // Transfer FSM with registered engine controls
  // ---------------------------------------------------------------------
  // Sequence one byte through the engine; outputs are set on the edge that
  // enters a state so they are clean register outputs during that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bufme  <= 1'b0;
      r_eng_en <= 1'b0;
      r_eng_sh <= 1'b0;
      r_in8    <= 8'h00;
    end else begin
      // NOTE: every branch of this case either assigns a register or leaves
      // it holding; the default arm keeps illegal encodings from sticking.
      unique case (r_state)
        S_IDLE: begin
          if (enable && !w_tx_empty && !w_rx_full) begin
            r_state <= S_LOAD;
            r_bufme <= 1'b1;
            r_in8   <= w_tx_head;
          end
        end

        S_LOAD: begin
          r_bufme <= 1'b0;
          r_cnt   <= '0;
          if (enable) begin
            r_state  <= S_SHIFT;
            r_eng_en <= 1'b1;
            r_eng_sh <= 1'b1;
          end else begin
            r_state  <= S_RELEASE;
          end
        end

        S_SHIFT: begin
          // Dropping enable wins over a simultaneous eng_BF: no capture.
          if (!enable || eng_BF || w_tmo_evt) begin
            r_eng_en <= 1'b0;
            r_eng_sh <= 1'b0;
            r_state  <= (enable && eng_BF) ? S_CAPTURE : S_RELEASE;
          end else begin
            r_cnt    <= r_cnt + CNT_ONE;
          end
        end

        S_CAPTURE: r_state <= S_RELEASE;

        S_RELEASE: r_state <= S_IDLE;

        default: begin
          r_state  <= S_IDLE;
          r_bufme  <= 1'b0;
          r_eng_en <= 1'b0;
          r_eng_sh <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  // Hold errors until err_clr; a fresh event in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !err_clr) || w_ovf_evt;
      r_tmo <= (r_tmo && !err_clr) || w_tmo_evt;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign rd_data   = r_rx_mem[r_rx_rd[AW-1:0]];
  assign tx_full   = w_tx_full;
  assign tx_empty  = w_tx_empty;
  assign rx_full   = w_rx_full;
  assign rx_empty  = w_rx_empty;
  assign busy      = (r_state != S_IDLE);
  assign ovf       = r_ovf;
  assign tmo       = r_tmo;
  assign eng_in8   = r_in8;
  assign eng_bufMe = r_bufme;
  assign eng_EN    = r_eng_en;
  assign eng_Sh    = r_eng_sh;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: directed scenarios plus a randomized run, all
// scored against a queue-based model of the two FIFOs and the error flags.
// A small engine model answers each byte b with b ^ 8'h99 after a
// programmable number of shift cycles (or never, to force a timeout).
module tb_spi_xfer_ctrl;

  localparam int D   = 4;
  localparam int TMO = 64;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       tx_full, tx_empty, rx_full, rx_empty, busy;
  logic       ovf, tmo, err_clr;
  logic [7:0] eng_in8;
  logic       eng_bufMe, eng_EN, eng_Sh;
  logic       eng_BF;
  logic [7:0] eng_out8;

  spi_xfer_ctrl #(.FIFO_DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full),
    .rx_empty(rx_empty), .busy(busy), .ovf(ovf), .tmo(tmo),
    .err_clr(err_clr), .eng_in8(eng_in8), .eng_bufMe(eng_bufMe),
    .eng_EN(eng_EN), .eng_Sh(eng_Sh), .eng_BF(eng_BF), .eng_out8(eng_out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- engine model ----------------
  int         eng_delay;
  bit         eng_never;
  int         e_cnt;
  logic [7:0] e_sh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt    <= 0;
      e_sh     <= 8'h00;
      eng_BF   <= 1'b0;
      eng_out8 <= 8'h00;
    end else begin
      if (eng_bufMe) e_sh <= eng_in8;
      if (eng_EN && eng_Sh) begin
        e_cnt <= e_cnt + 1;
        if (!eng_never && (e_cnt + 1 >= eng_delay)) begin
          eng_BF   <= 1'b1;
          eng_out8 <= e_sh ^ 8'h99;
        end
      end else begin
        e_cnt  <= 0;
        eng_BF <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] inflight;
  bit         pend;       // engine result accepted, push due on next edge
  bit         m_ovf, m_tmo;
  bit         load_ok;    // a LOAD is legal on the coming edge
  int         shift_cnt;
  int         n_bufme, n_shift;

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    pend      = 1'b0;
    m_ovf     = 1'b0;
    m_tmo     = 1'b0;
    load_ok   = 1'b0;
    shift_cnt = 0;
  endtask

  // One clock: update the model from pre-edge inputs/outputs, take the
  // edge, then compare the DUT against the model.
  task automatic step();
    int txc, rxc;
    bit tx_pop, rx_pop, ovf_ev, tmo_ev;
    txc    = tx_q.size();
    rxc    = rx_q.size();
    ovf_ev = 1'b0;
    tmo_ev = 1'b0;
    tx_pop = eng_bufMe;
    if (eng_bufMe) begin
      n_bufme++;
      check("load_cond", 32'(load_ok), 32'd1);
      if (txc == 0) check("load_tx_empty", 32'd1, 32'd0);
      else begin
        check("eng_in8", 32'(eng_in8), 32'(tx_q[0]));
        inflight = tx_q.pop_front();
      end
    end
    load_ok = enable && (txc > 0) && (rxc < D);
    if (wr_en) begin
      if (txc < D || tx_pop) tx_q.push_back(wr_data);
      else ovf_ev = 1'b1;
    end
    if (eng_EN) begin
      n_shift++;
      if (enable && !eng_BF && shift_cnt == TMO - 1) tmo_ev = 1'b1;
      shift_cnt++;
    end else begin
      shift_cnt = 0;
    end
    rx_pop = rd_en && (rxc > 0);
    if (rx_pop) void'(rx_q.pop_front());
    if (pend && (rxc < D || rx_pop)) rx_q.push_back(inflight ^ 8'h99);
    pend  = eng_EN && eng_BF && enable;
    m_ovf = (m_ovf && !err_clr) || ovf_ev;
    m_tmo = (m_tmo && !err_clr) || tmo_ev;

    @(posedge clk);
    #1;
    check("tx_full",  32'(tx_full),  32'(tx_q.size() == D));
    check("tx_empty", 32'(tx_empty), 32'(tx_q.size() == 0));
    check("rx_full",  32'(rx_full),  32'(rx_q.size() == D));
    check("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
    check("ovf",      32'(ovf),      32'(m_ovf));
    check("tmo",      32'(tmo),      32'(m_tmo));
    if (rx_q.size() > 0) check("rd_data", 32'(rd_data), 32'(rx_q[0]));
    if (eng_bufMe || eng_EN) check("busy_active", 32'(busy), 32'd1);
    check("ctl_excl", 32'(eng_bufMe && eng_EN), 32'd0);
  endtask

  // Run with enable held until nothing more can start.
  task automatic run_until_quiet(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = !busy && !pend && (tx_q.size() == 0 || rx_q.size() == D);
    end
    check("quiet_timeout", 32'(done), 32'd1);
  endtask

  // Transfer and read out everything that is queued.
  task automatic flush(input int budget);
    bit done;
    done    = 1'b0;
    enable  = 1'b1;
    wr_en   = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      rd_en = (rx_q.size() > 0);
      step();
      done = !busy && !pend && tx_q.size() == 0 && rx_q.size() == 0;
    end
    rd_en = 1'b0;
    check("flush_timeout", 32'(done), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_shift(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      seen = eng_EN;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [5];
    int base;
    bit seen;
    n_checks  = 0;
    n_fail    = 0;
    n_bufme   = 0;
    n_shift   = 0;
    eng_delay = 3;
    eng_never = 1'b0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    rd_en     = 1'b0;
    err_clr   = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_txe",   32'(tx_empty),  32'd1);
    check("rst_rxe",   32'(rx_empty),  32'd1);
    check("rst_txf",   32'(tx_full),   32'd0);
    check("rst_rxf",   32'(rx_full),   32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    check("rst_tmo",   32'(tmo),       32'd0);
    check("rst_bufme", 32'(eng_bufMe), 32'd0);
    check("rst_en",    32'(eng_EN),    32'd0);
    check("rst_sh",    32'(eng_Sh),    32'd0);
    check("rst_in8",   32'(eng_in8),   32'h00);
    rst_n = 1'b1;

    // Read of empty RX is ignored; single byte round trip A5 -> 3C
    rd_en = 1'b1;
    step();
    rd_en  = 1'b0;
    enable = 1'b1;
    base   = n_bufme;
    push_byte(8'hA5);
    run_until_quiet(100);
    check("a5_pulses",  32'(n_bufme - base), 32'd1);
    check("a5_in8",     32'(eng_in8),        32'hA5);
    check("a5_rd_data", 32'(rd_data),        32'h3C);
    check("a5_rxe",     32'(rx_empty),       32'd0);
    check("a5_txe",     32'(tx_empty),       32'd1);
    flush(50);

    // Five writes with enable low: 5th dropped, first four sent in order
    enable = 1'b0;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    seq[4] = 8'h55;
    for (int i = 0; i < 5; i++) push_byte(seq[i]);
    check("ovf5_txf", 32'(tx_full), 32'd1);
    check("ovf5_ovf", 32'(ovf),     32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf5_clr", 32'(ovf), 32'd0);
    enable = 1'b1;
    run_until_quiet(200);
    check("ovf5_rxf", 32'(rx_full),  32'd1);
    check("ovf5_txe", 32'(tx_empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("ovf5_order", 32'(rd_data), 32'(seq[i] ^ 8'h99));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("ovf5_drained", 32'(rx_empty), 32'd1);

    // RX full with TX pending: stay idle until one read frees space
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h01 + i));
    enable = 1'b1;
    run_until_quiet(200);
    push_byte(8'hE1);
    push_byte(8'hE2);
    base = n_bufme;
    repeat (10) step();
    check("rxfull_noload", 32'(n_bufme - base), 32'd0);
    check("rxfull_busy",   32'(busy),           32'd0);
    check("rxfull_txne",   32'(tx_empty),       32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = eng_bufMe;
    end
    check("rxfull_restart", 32'(seen), 32'd1);
    flush(300);

    // Engine never answers: timeout after TMO shift cycles
    eng_never = 1'b1;
    base      = n_shift;
    push_byte(8'h5A);
    run_until_quiet(300);
    check("tmo_cycles", 32'(n_shift - base), 32'(TMO));
    check("tmo_flag",   32'(tmo),            32'd1);
    check("tmo_rxe",    32'(rx_empty),       32'd1);
    check("tmo_idle",   32'(busy),           32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("tmo_clr", 32'(tmo), 32'd0);
    eng_never = 1'b0;

    // err_clr in the same cycle as a new overflow keeps ovf set
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h70 + i));
    wr_en   = 1'b1;
    wr_data = 8'h7F;
    err_clr = 1'b1;
    step();
    check("ovf_clr_race", 32'(ovf), 32'd1);
    wr_en = 1'b0;
    step();
    err_clr = 1'b0;
    check("ovf_clr_only", 32'(ovf), 32'd0);

    // Push into full TX while transfers pop it
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h80 + i);
      step();
    end
    wr_en = 1'b0;
    flush(800);

    // Enable dropped mid-SHIFT: engine released, no capture
    eng_delay = 20;
    push_byte(8'hC3);
    wait_shift("drop_reach_shift");
    enable = 1'b0;
    step();
    check("drop_sh",   32'(eng_Sh),   32'd0);
    check("drop_en",   32'(eng_EN),   32'd0);
    step();
    check("drop_busy", 32'(busy),     32'd0);
    check("drop_rxe",  32'(rx_empty), 32'd1);
    repeat (3) step();
    check("drop_rxe2", 32'(rx_empty), 32'd1);

    // Reset asserted mid-SHIFT aborts at once
    enable = 1'b1;
    push_byte(8'h3E);
    push_byte(8'h3F);
    wait_shift("rst_reach_shift");
    #2 rst_n = 1'b0;
    #1;
    check("rstx_sh",   32'(eng_Sh),   32'd0);
    check("rstx_busy", 32'(busy),     32'd0);
    check("rstx_txe",  32'(tx_empty), 32'd1);
    check("rstx_rxe",  32'(rx_empty), 32'd1);
    check("rstx_in8",  32'(eng_in8),  32'h00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rstx_after_rxe", 32'(rx_empty), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      enable    = ($urandom_range(0, 7) != 0);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_data   = 8'($urandom);
      rd_en     = (rx_q.size() > 0) && ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      eng_delay = $urandom_range(1, 6);
      step();
    end
    rd_en = 1'b0;
    flush(2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
